mmul2_sequencer: RTL and testbench
==================================

# mmul2_sequencer

Control sequencer for the matrix-multiply datapath: on `start` it walks the triple loop over i (row of A), j (column of B) and k (inner index). For each step it issues read addresses to the A and B operand memories, drives the MAC clear/enable controls and writes each finished C element. It sits between the host control logic and the MAC/memory datapath, and checks the dimension configuration before running.

## Interface
- `RA`, default 2: rows of A.
- `CA`, default 2: columns of A (inner dimension).
- `RB`, default 2: rows of B; must equal `CA`.
- `CB`, default 2: columns of B.
- `LAT`, default 1: operand memory read latency in cycles, ≥1.
- Derived address widths: AW_A=max(1,$clog2(RA*CA)), AW_B=max(1,$clog2(RB*CB)), AW_C=max(1,$clog2(RA*CB)).
- `clk`, input, 1: clock. Rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: single-cycle request to begin a multiply. Sampled only in IDLE.
- `stall`, input, 1: when high, holds operand issue.
- `rd_en`, output, 1: operand read strobe for both memories.
- `a_addr`, output, AW_A: A address = i*CA+k.
- `b_addr`, output, AW_B: B address = k*CB+j.
- `mac_en`, output, 1: operands are valid at the MAC this cycle.
- `mac_clr`, output, 1: with `mac_en`, load the product instead of accumulating (k==0).
- `c_we`, output, 1: write the accumulator to C.
- `c_addr`, output, AW_C: C address = i*CB+j.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle completion pulse.
- `err`, output, 1: registered; set when a start is rejected; cleared by the next accepted start.

## Operation
- Config is valid when CA==RB and RA, CA, RB, CB are all nonzero. Validity is evaluated from the parameters as a constant.
- States and transitions:
  - IDLE: on `start` with a valid config, go to RUN with i=j=k=0. On `start` with an invalid config, go to ERR.
  - RUN: each cycle with `stall` low, present (i,j,k) with `rd_en`=1, then advance the counters. k counts fastest, then j, then i. After issuing (RA-1, CB-1, CA-1), go to DRAIN.
  - DRAIN: wait until the pipeline holds no valid entries and the last `c_we` has issued, then go to DONE.
  - DONE: pulse `done`, then go to IDLE.
  - ERR: pulse `done`, set `err`, then go to IDLE. No `rd_en`, `mac_en` or `c_we` is ever produced.
- `stall` in RUN: `rd_en`=0 and the counters hold. Reads already in flight still complete; the delay pipeline is never frozen. `stall` has no effect outside RUN.
- Delay pipeline, LAT stages, carries {valid, first=(k==0), last=(k==CA-1), c index}. At stage LAT out: `mac_en`=valid, `mac_clr`=valid&first.
- `c_we` and `c_addr` are asserted one cycle after the `mac_en` cycle whose last flag is set, because the accumulator is registered.
- `start` while `busy` is ignored.
- Counters wrap to 0 at their bound. Address products fit in the declared widths with no truncation.

## Timing
- Reset, asynchronous: state=IDLE, counters 0, pipeline cleared. All outputs are 0, including `err`, `busy` and all addresses.
- Reset asserted mid-operation: all outputs drop to 0 immediately. No further `c_we`. Operation resumes only on a new `start`.
- All outputs are registered.
- With `start` high at edge 0 and no stalls (N=RA*CA*CB):
  - `rd_en` is high in cycles 1..N.
  - `mac_en` is high in cycles 1+LAT..N+LAT.
  - The final `c_we` occurs in cycle N+LAT+1.
  - `done` occurs in cycle N+LAT+2.
  - `busy` is high in cycles 1..N+LAT+2.
  - `start` is accepted again in cycle N+LAT+3.
- Each stall cycle in RUN adds exactly one cycle to all subsequent events.
- Invalid config: `busy`, `done` and `err` are high in cycle 1. `busy` is low in cycle 2. `err` stays high.

## Test plan
- RA=2, CA=RB=3, CB=2, LAT=1, start at cycle 0:
  - (a_addr,b_addr) sequence is (0,0),(1,2),(2,4),(0,1),(1,3),(2,5),(3,0)... over cycles 1..12.
  - `mac_clr` in cycles 2, 5, 8, 11.
  - `c_we` in cycles 5, 8, 11, 14 with `c_addr` 0, 1, 2, 3.
  - `done` in cycle 15.
- CA=3, RB=2, start: `done` and `err` in cycle 1, no `rd_en`/`mac_en`/`c_we` ever. A later start with the same config repeats the same response.
- All dimensions 1, LAT=2:
  - `rd_en` in cycle 1, `mac_en`+`mac_clr` in cycle 3, `c_we` with `c_addr`=0 in cycle 4, `done` in cycle 5.
- 2x2x2, LAT=1, `stall` high in cycles 3-4:
  - `rd_en` low in cycles 3-4.
  - The issued address sequence matches the unstalled run.
  - `done` moves from cycle 11 to cycle 13.
- Reset pulse in cycle 4 of a 2x2x2 run: all outputs are 0 that cycle and no `c_we` follows. A fresh start produces the full nominal sequence.
- `start` pulses in cycles 3 and 6 during a run are ignored: outputs are identical to the single-start run, and a single `done`.

Source files
------------

// File: rtl/mmul2_sequencer_if.sv
// Host/datapath bundle for mmul2_sequencer: start/stall in, memory, MAC and C-write controls out.
// Address widths derive from the matrix dimensions so both ends agree.
interface mmul2_sequencer_if #(
    parameter int RA = 2,
    parameter int CA = 2,
    parameter int RB = 2,
    parameter int CB = 2
) ();
    localparam int AW_A = (RA * CA > 1) ? $clog2(RA * CA) : 1;
    localparam int AW_B = (RB * CB > 1) ? $clog2(RB * CB) : 1;
    localparam int AW_C = (RA * CB > 1) ? $clog2(RA * CB) : 1;

    logic            start;
    logic            stall;
    logic            rd_en;
    logic [AW_A-1:0] a_addr;
    logic [AW_B-1:0] b_addr;
    logic            mac_en;
    logic            mac_clr;
    logic            c_we;
    logic [AW_C-1:0] c_addr;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        input  start, stall,
        output rd_en, a_addr, b_addr, mac_en, mac_clr, c_we, c_addr, busy, done, err
    );

    modport slave (
        output start, stall,
        input  rd_en, a_addr, b_addr, mac_en, mac_clr, c_we, c_addr, busy, done, err
    );
endinterface

// File: rtl/mmul2_sequencer.sv
// Matrix-multiply control sequencer: walks i/j/k, issues operand reads, tracks them through a
// LAT-deep delay line to drive MAC clear/enable, and writes each finished C element.
module mmul2_sequencer #(
    parameter int RA  = 2,
    parameter int CA  = 2,
    parameter int RB  = 2,
    parameter int CB  = 2,
    parameter int LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mmul2_sequencer_if.master bus
);
    localparam int AW_A = (RA * CA > 1) ? $clog2(RA * CA) : 1;
    localparam int AW_B = (RB * CB > 1) ? $clog2(RB * CB) : 1;
    localparam int AW_C = (RA * CB > 1) ? $clog2(RA * CB) : 1;
    localparam int IW   = (RA > 1) ? $clog2(RA) : 1;
    localparam int JW   = (CB > 1) ? $clog2(CB) : 1;
    localparam int KW   = (CA > 1) ? $clog2(CA) : 1;

    localparam bit CFG_OK = (CA == RB) && (RA != 0) && (CA != 0) && (RB != 0) && (CB != 0);

    localparam logic [IW-1:0] I_MAX = IW'(RA - 1);
    localparam logic [JW-1:0] J_MAX = JW'(CB - 1);
    localparam logic [KW-1:0] K_MAX = KW'(CA - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [IW-1:0]   i_r, i_s;
    logic [JW-1:0]   j_r, j_s;
    logic [KW-1:0]   k_r, k_s;

    logic            rd_en_s, accept_s, last_issue_s, drained_s;
    logic            busy_s, done_s, err_s;
    logic [AW_A-1:0] a_addr_s;
    logic [AW_B-1:0] b_addr_s;
    logic [AW_C-1:0] c_idx_s;

    // Delay line entries: valid, first (k==0), last (k==CA-1), C index.
    logic [LAT-1:0]  pv_r, pf_r, pl_r;
    logic [AW_C-1:0] pc_r [LAT];

    logic            rd_en_r, mac_en_r, mac_clr_r, mac_last_r, c_we_r;
    logic            busy_r, done_r, err_r;
    logic [AW_A-1:0] a_addr_r;
    logic [AW_B-1:0] b_addr_r;
    logic [AW_C-1:0] mac_idx_r, c_addr_r;

    assign last_issue_s = (i_r == I_MAX) && (j_r == J_MAX) && (k_r == K_MAX);
    // The final entry has left the delay line and its c_we is being registered this edge.
    assign drained_s    = (pv_r == {LAT{1'b0}}) && !(mac_en_r && !mac_last_r);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state plus next values of the state-derived outputs.
    always_comb begin
        state_s  = state_r;
        rd_en_s  = 1'b0;
        accept_s = 1'b0;
        err_s    = err_r;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    if (CFG_OK) begin
                        state_s  = S_RUN;
                        accept_s = 1'b1;
                        err_s    = 1'b0;
                    end else begin
                        state_s = S_ERR;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (!bus.stall) begin
                    rd_en_s = 1'b1;
                    if (last_issue_s) begin
                        state_s = S_DRAIN;
                    end else begin
                        state_s = S_RUN;
                    end
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DRAIN: begin
                if (drained_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            S_ERR: begin
                err_s   = 1'b1;
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        busy_s = (state_r != S_IDLE);
        done_s = (state_r == S_DONE) || (state_r == S_ERR);
    end

    // Loop counters: k fastest, then j, then i; each wraps to zero at its bound.
    always_comb begin
        i_s = i_r;
        j_s = j_r;
        k_s = k_r;
        if (accept_s) begin
            i_s = {IW{1'b0}};
            j_s = {JW{1'b0}};
            k_s = {KW{1'b0}};
        end else if (rd_en_s) begin
            if (k_r == K_MAX) begin
                k_s = {KW{1'b0}};
                if (j_r == J_MAX) begin
                    j_s = {JW{1'b0}};
                    if (i_r == I_MAX) begin
                        i_s = {IW{1'b0}};
                    end else begin
                        i_s = i_r + {{(IW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    j_s = j_r + {{(JW-1){1'b0}}, 1'b1};
                end
            end else begin
                k_s = k_r + {{(KW-1){1'b0}}, 1'b1};
            end
        end else begin
            k_s = k_r;
        end
    end

    // Addresses for the current (i,j,k).
    always_comb begin
        a_addr_s = AW_A'(int'(i_r) * CA + int'(k_r));
        b_addr_s = AW_B'(int'(k_r) * CB + int'(j_r));
        c_idx_s  = AW_C'(int'(i_r) * CB + int'(j_r));
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_r <= {IW{1'b0}};
            j_r <= {JW{1'b0}};
            k_r <= {KW{1'b0}};
        end else begin
            i_r <= i_s;
            j_r <= j_s;
            k_r <= k_s;
        end
    end

    // Read-latency delay line; never frozen by stall so in-flight reads complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_r <= {LAT{1'b0}};
            pf_r <= {LAT{1'b0}};
            pl_r <= {LAT{1'b0}};
            for (int s = 0; s < LAT; s++) begin
                pc_r[s] <= {AW_C{1'b0}};
            end
        end else begin
            pv_r[0] <= rd_en_s;
            pf_r[0] <= (k_r == {KW{1'b0}});
            pl_r[0] <= (k_r == K_MAX);
            pc_r[0] <= c_idx_s;
            for (int s = 1; s < LAT; s++) begin
                pv_r[s] <= pv_r[s-1];
                pf_r[s] <= pf_r[s-1];
                pl_r[s] <= pl_r[s-1];
                pc_r[s] <= pc_r[s-1];
            end
        end
    end

    // Output registers; c_we trails the last mac_en by one cycle for the registered accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_r    <= 1'b0;
            a_addr_r   <= {AW_A{1'b0}};
            b_addr_r   <= {AW_B{1'b0}};
            mac_en_r   <= 1'b0;
            mac_clr_r  <= 1'b0;
            mac_last_r <= 1'b0;
            mac_idx_r  <= {AW_C{1'b0}};
            c_we_r     <= 1'b0;
            c_addr_r   <= {AW_C{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            rd_en_r    <= rd_en_s;
            a_addr_r   <= rd_en_s ? a_addr_s : {AW_A{1'b0}};
            b_addr_r   <= rd_en_s ? b_addr_s : {AW_B{1'b0}};
            mac_en_r   <= pv_r[LAT-1];
            mac_clr_r  <= pv_r[LAT-1] & pf_r[LAT-1];
            mac_last_r <= pv_r[LAT-1] & pl_r[LAT-1];
            mac_idx_r  <= pc_r[LAT-1];
            c_we_r     <= mac_en_r & mac_last_r;
            c_addr_r   <= (mac_en_r & mac_last_r) ? mac_idx_r : {AW_C{1'b0}};
            busy_r     <= busy_s;
            done_r     <= done_s;
            err_r      <= err_s;
        end
    end

    assign bus.rd_en   = rd_en_r;
    assign bus.a_addr  = a_addr_r;
    assign bus.b_addr  = b_addr_r;
    assign bus.mac_en  = mac_en_r;
    assign bus.mac_clr = mac_clr_r;
    assign bus.c_we    = c_we_r;
    assign bus.c_addr  = c_addr_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.err     = err_r;
endmodule

// File: tb/tb_mmul2_sequencer.sv
// Directed bench for mmul2_sequencer: four configurations, hand-computed cycle-by-cycle expectations.
// Cycle n is sampled 1 ns after rising edge n; start is sampled at edge 0.
module tb_mmul2_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    mmul2_sequencer_if #(.RA(2), .CA(3), .RB(3), .CB(2)) if1 ();
    mmul2_sequencer_if #(.RA(2), .CA(3), .RB(2), .CB(2)) if2 ();
    mmul2_sequencer_if #(.RA(1), .CA(1), .RB(1), .CB(1)) if3 ();
    mmul2_sequencer_if #(.RA(2), .CA(2), .RB(2), .CB(2)) if4 ();

    mmul2_sequencer #(.RA(2), .CA(3), .RB(3), .CB(2), .LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mmul2_sequencer #(.RA(2), .CA(3), .RB(2), .CB(2), .LAT(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    mmul2_sequencer #(.RA(1), .CA(1), .RB(1), .CB(1), .LAT(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    mmul2_sequencer #(.RA(2), .CA(2), .RB(2), .CB(2), .LAT(1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    int a1_exp [12] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
    int b1_exp [12] = '{0, 2, 4, 1, 3, 5, 0, 2, 4, 1, 3, 5};
    int a4_exp [8]  = '{0, 1, 0, 1, 2, 3, 2, 3};
    int b4_exp [8]  = '{0, 2, 1, 3, 0, 2, 1, 3};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h want %0h", tag, cyc, got, want);
        end
    endtask

    function automatic logic [31:0] ctl(input logic rd, input logic me, input logic mc, input logic cw,
                                        input logic bz, input logic dn, input logic er);
        return {25'd0, rd, me, mc, cw, bz, dn, er};
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Unstalled 2x2x2 run on dut4, optionally with extra start pulses at edges 3 and 6.
    task automatic nominal(input bit extra);
        int ci;
        ci  = 0;
        cyc = -1;
        if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if4.start = extra && (c == 3 || c == 6);
            tick();
            if4.start = 1'b0;
            check("n_ctl", ctl(if4.rd_en, if4.mac_en, if4.mac_clr, if4.c_we, if4.busy, if4.done, if4.err),
                  ctl(c <= 8, c >= 2 && c <= 9, c == 2 || c == 4 || c == 6 || c == 8,
                      c == 4 || c == 6 || c == 8 || c == 10, c <= 11, c == 11, 1'b0));
            if (c <= 8) begin
                check("n_a", 32'(if4.a_addr), a4_exp[c-1]);
                check("n_b", 32'(if4.b_addr), b4_exp[c-1]);
            end
            if (c == 4 || c == 6 || c == 8 || c == 10) begin
                check("n_caddr", 32'(if4.c_addr), ci);
                ci++;
            end
        end
    endtask

    initial begin
        int ci;
        int idx;
        if1.start = 1'b0; if1.stall = 1'b0;
        if2.start = 1'b0; if2.stall = 1'b0;
        if3.start = 1'b0; if3.stall = 1'b0;
        if4.start = 1'b0; if4.stall = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst1", 32'({if1.rd_en, if1.a_addr, if1.b_addr, if1.mac_en, if1.mac_clr, if1.c_we,
                           if1.c_addr, if1.busy, if1.done, if1.err}), 32'd0);
        check("rst4", 32'({if4.rd_en, if4.a_addr, if4.b_addr, if4.mac_en, if4.mac_clr, if4.c_we,
                           if4.c_addr, if4.busy, if4.done, if4.err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // 2x3 * 3x2, LAT=1
        cyc = -1;
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        ci = 0;
        for (int c = 1; c <= 17; c++) begin
            tick();
            check("t1_ctl", ctl(if1.rd_en, if1.mac_en, if1.mac_clr, if1.c_we, if1.busy, if1.done, if1.err),
                  ctl(c <= 12, c >= 2 && c <= 13, c == 2 || c == 5 || c == 8 || c == 11,
                      c == 5 || c == 8 || c == 11 || c == 14, c <= 15, c == 15, 1'b0));
            if (c <= 12) begin
                check("t1_a", 32'(if1.a_addr), a1_exp[c-1]);
                check("t1_b", 32'(if1.b_addr), b1_exp[c-1]);
            end
            if (c == 5 || c == 8 || c == 11 || c == 14) begin
                check("t1_caddr", 32'(if1.c_addr), ci);
                ci++;
            end
        end

        // Invalid configuration, started twice
        for (int r = 0; r < 2; r++) begin
            cyc = -1;
            if2.start = 1'b1;
            tick();
            if2.start = 1'b0;
            for (int c = 1; c <= 5; c++) begin
                tick();
                check("t2_ctl", ctl(if2.rd_en, if2.mac_en, if2.mac_clr, if2.c_we, if2.busy, if2.done, if2.err),
                      ctl(1'b0, 1'b0, 1'b0, 1'b0, c == 1, c == 1, 1'b1));
            end
        end

        // All dimensions 1, LAT=2
        cyc = -1;
        if3.start = 1'b1;
        tick();
        if3.start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check("t3_ctl", ctl(if3.rd_en, if3.mac_en, if3.mac_clr, if3.c_we, if3.busy, if3.done, if3.err),
                  ctl(c == 1, c == 3, c == 3, c == 4, c <= 5, c == 5, 1'b0));
            if (c == 1) begin
                check("t3_ab", 32'({if3.a_addr, if3.b_addr}), 32'd0);
            end
            if (c == 4) begin
                check("t3_caddr", 32'(if3.c_addr), 32'd0);
            end
        end

        // 2x2x2 with stall at edges 3 and 4
        cyc = -1;
        if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        idx = 0;
        ci  = 0;
        for (int c = 1; c <= 15; c++) begin
            if4.stall = (c == 3 || c == 4);
            tick();
            if4.stall = 1'b0;
            check("t4_ctl", ctl(if4.rd_en, if4.mac_en, if4.mac_clr, if4.c_we, if4.busy, if4.done, if4.err),
                  ctl(c <= 2 || (c >= 5 && c <= 10), c == 2 || c == 3 || (c >= 6 && c <= 11),
                      c == 2 || c == 6 || c == 8 || c == 10, c == 4 || c == 8 || c == 10 || c == 12,
                      c <= 13, c == 13, 1'b0));
            if (c <= 2 || (c >= 5 && c <= 10)) begin
                check("t4_a", 32'(if4.a_addr), a4_exp[idx]);
                check("t4_b", 32'(if4.b_addr), b4_exp[idx]);
                idx++;
            end
            if (c == 4 || c == 8 || c == 10 || c == 12) begin
                check("t4_caddr", 32'(if4.c_addr), ci);
                ci++;
            end
        end

        // Reset pulse in cycle 4 of a 2x2x2 run, then a fresh nominal run
        cyc = -1;
        if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
        end
        check("t5_pre", 32'({if4.busy, if4.rd_en}), 32'd3);
        rst_n = 1'b0;
        #1;
        check("t5_rst", 32'({if4.rd_en, if4.a_addr, if4.b_addr, if4.mac_en, if4.mac_clr, if4.c_we,
                             if4.c_addr, if4.busy, if4.done, if4.err}), 32'd0);
        #3;
        rst_n = 1'b1;
        for (int c = 5; c <= 16; c++) begin
            tick();
            check("t5_quiet", ctl(if4.rd_en, if4.mac_en, if4.mac_clr, if4.c_we, if4.busy, if4.done, if4.err),
                  32'd0);
        end
        nominal(1'b0);

        // Extra starts during the run are ignored
        nominal(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
